// File: rtl/meta_queue_pkg.sv
// Shared constants and helper types for the meta queue: default depth, stat
// counter width and the push/pop operation encoding used by the occupancy logic.
package meta_queue_pkg;

   localparam int META_QUEUE_DEPTH_DEF = 8;
   localparam int META_STAT_BITS       = 32;
   localparam int META_DATA_BITS_DEF   = 96;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } q_op_e;

   function automatic q_op_e q_op(input logic push, input logic pop);
      return q_op_e'({pop, push});
   endfunction

endpackage

// File: rtl/meta_queue_if.sv
// Valid/ready/data meta stream between the arbiter, the queue and the consumer.
// Modport m drives the stream, modport s receives it.
interface meta_queue_if
   import meta_queue_pkg::*;
#(
   parameter int DATA_BITS = META_DATA_BITS_DEF
) ();

   logic                 valid;
   logic                 ready;
   logic [DATA_BITS-1:0] data;

   modport m (output valid, output data, input ready);
   modport s (input valid, input data, output ready);

endinterface

// File: rtl/meta_queue_stats.sv
// Push/pop/stall event counters for the meta queue; compiled only when
// META_QUEUE_STATS_EN is defined. All counters wrap and clear on reset.
`ifdef META_QUEUE_STATS_EN
module meta_queue_stats
   import meta_queue_pkg::*;
#(
   parameter int CNT_BITS = META_STAT_BITS
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                i_push,
   input  logic                i_pop,
   input  logic                i_stall,
   output logic [CNT_BITS-1:0] o_stat_push,
   output logic [CNT_BITS-1:0] o_stat_pop,
   output logic [CNT_BITS-1:0] o_stat_stall
);

   logic [CNT_BITS-1:0] r_push_cnt;
   logic [CNT_BITS-1:0] r_pop_cnt;
   logic [CNT_BITS-1:0] r_stall_cnt;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_push_cnt  <= '0;
         r_pop_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (i_push)  r_push_cnt  <= r_push_cnt  + CNT_BITS'(1);
         if (i_pop)   r_pop_cnt   <= r_pop_cnt   + CNT_BITS'(1);
         if (i_stall) r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
      end
   end

   assign o_stat_push  = r_push_cnt;
   assign o_stat_pop   = r_pop_cnt;
   assign o_stat_stall = r_stall_cnt;

endmodule
`endif

// File: rtl/meta_queue.sv
// Elastic FIFO behind the 2:1 meta arbiter, first-word fall-through, fully registered
// status. Define META_QUEUE_STATS_EN to add the push/pop/stall counters.
module meta_queue
   import meta_queue_pkg::*;
#(
   parameter int QDEPTH    = META_QUEUE_DEPTH_DEF,
   parameter int DATA_BITS = META_DATA_BITS_DEF,
   parameter int AFULL_THR = QDEPTH - 2
) (
   input  logic                    aclk,
   input  logic                    areset,
   meta_queue_if.s                 s_meta,
   meta_queue_if.m                 m_meta,
   output logic [$clog2(QDEPTH):0] occ,
   output logic                    afull
`ifdef META_QUEUE_STATS_EN
   ,
   output logic [META_STAT_BITS-1:0] stat_push,
   output logic [META_STAT_BITS-1:0] stat_pop,
   output logic [META_STAT_BITS-1:0] stat_stall
`endif
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(QDEPTH);
   localparam logic [OCC_W-1:0] OCC_AFULL = OCC_W'(AFULL_THR);

   if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_depth
      $error("meta_queue: QDEPTH must be a power of two >= 2");
   end
   if (AFULL_THR < 1 || AFULL_THR > QDEPTH) begin : g_bad_thr
      $error("meta_queue: AFULL_THR must lie in 1..QDEPTH");
   end
   if ($bits(s_meta.data) != DATA_BITS || $bits(m_meta.data) != DATA_BITS) begin : g_bad_width
      $error("meta_queue: DATA_BITS must match the stream data width");
   end

   logic [DATA_BITS-1:0] r_mem [QDEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [OCC_W-1:0]     r_occ;
   logic                 r_afull;

   logic [OCC_W-1:0]     w_occ_nxt;
   logic                 w_s_ready;
   logic                 w_m_valid;
   logic                 w_push;
   logic                 w_pop;
   q_op_e                w_op;

   // Handshakes depend only on registered occupancy, so s_meta.ready never sees m_meta.ready.
   assign w_s_ready = (r_occ != OCC_FULL);
   assign w_m_valid = (r_occ != '0);
   assign w_push    = s_meta.valid & w_s_ready;
   assign w_pop     = w_m_valid & m_meta.ready;
   assign w_op      = q_op(w_push, w_pop);

   assign s_meta.ready = w_s_ready;
   assign m_meta.valid = w_m_valid;
   // Gating with valid keeps the output at zero while empty and throughout reset.
   assign m_meta.data  = w_m_valid ? r_mem[r_rd_ptr] : '0;

   always_comb begin
      w_occ_nxt = r_occ;
      case (w_op)
         OP_PUSH: w_occ_nxt = r_occ + OCC_W'(1);
         OP_POP:  w_occ_nxt = r_occ - OCC_W'(1);
         default: w_occ_nxt = r_occ;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_afull  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_occ   <= w_occ_nxt;
         r_afull <= (w_occ_nxt >= OCC_AFULL);
      end
   end

   // Payload storage carries no reset; slots are only read once written.
   always_ff @(posedge aclk) begin
      if (w_push) r_mem[r_wr_ptr] <= s_meta.data;
   end

   assign occ   = r_occ;
   assign afull = r_afull;

`ifdef META_QUEUE_STATS_EN
   logic w_stall;
   assign w_stall = s_meta.valid & ~w_s_ready;

   meta_queue_stats #(
      .CNT_BITS (META_STAT_BITS)
   ) u_stats (
      .aclk         (aclk),
      .areset       (areset),
      .i_push       (w_push),
      .i_pop        (w_pop),
      .i_stall      (w_stall),
      .o_stat_push  (stat_push),
      .o_stat_pop   (stat_pop),
      .o_stat_stall (stat_stall)
   );
`endif

endmodule

// File: tb/tb_meta_queue.sv
// Scoreboard bench for meta_queue: a queue-based model tracks contents, status and
// counters; the monitor compares every cycle on the falling edge.
module tb_meta_queue;
   import meta_queue_pkg::*;

   localparam int QD = 8;
   localparam int DB = 96;
   localparam int AT = 6;

   logic aclk = 1'b0;
   logic areset;
   always #5 aclk = ~aclk;

   meta_queue_if #(.DATA_BITS(DB)) s_if ();
   meta_queue_if #(.DATA_BITS(DB)) m_if ();

   logic [3:0] occ;
   logic       afull;
`ifdef META_QUEUE_STATS_EN
   logic [31:0] stat_push, stat_pop, stat_stall;
`endif

   meta_queue #(.QDEPTH(QD), .DATA_BITS(DB), .AFULL_THR(AT)) dut (
      .aclk   (aclk),
      .areset (areset),
      .s_meta (s_if.s),
      .m_meta (m_if.m),
      .occ    (occ),
      .afull  (afull)
`ifdef META_QUEUE_STATS_EN
      ,
      .stat_push  (stat_push),
      .stat_pop   (stat_pop),
      .stat_stall (stat_stall)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic chkn(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: ordered contents plus event counts.
   logic [DB-1:0] exp_q[$];
   int            n_pop = 0;
   logic [31:0]   m_push = 0, m_pop = 0, m_stall = 0;

   always @(negedge aclk) begin : monitor
      int sz;
      if (areset) begin
         exp_q.delete();
         m_push  = 0;
         m_pop   = 0;
         m_stall = 0;
         chkn("rst_valid", longint'(m_if.valid), 0);
         chkn("rst_occ", longint'(occ), 0);
         chk("rst_data", m_if.data, '0);
`ifdef META_QUEUE_STATS_EN
         chkn("rst_stats", longint'(stat_push) + longint'(stat_pop) + longint'(stat_stall), 0);
`endif
      end else begin
         sz = exp_q.size();
         chkn("occ", longint'(occ), sz);
         chkn("occ_range", longint'(occ <= 4'(QD)), 1);
         chkn("m_valid", longint'(m_if.valid), longint'(sz != 0));
         chkn("s_ready", longint'(s_if.ready), longint'(sz != QD));
         chkn("afull", longint'(afull), longint'(sz >= AT));
         if (sz != 0) chk("head_data", m_if.data, exp_q[0]);
`ifdef META_QUEUE_STATS_EN
         chkn("stat_push", longint'(stat_push), longint'(m_push));
         chkn("stat_pop", longint'(stat_pop), longint'(m_pop));
         chkn("stat_stall", longint'(stat_stall), longint'(m_stall));
`endif
         if (sz != 0 && m_if.ready) begin
            void'(exp_q.pop_front());
            n_pop++;
            m_pop = m_pop + 1;
         end
         if (s_if.valid) begin
            if (sz != QD) begin
               exp_q.push_back(s_if.data);
               m_push = m_push + 1;
            end else begin
               m_stall = m_stall + 1;
            end
         end
      end
   end

   function automatic logic [DB-1:0] rnd96();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   task automatic cyc(input logic sv, input logic [DB-1:0] sd, input logic mr);
      s_if.valid  = sv;
      s_if.data   = sd;
      m_if.ready  = mr;
      @(posedge aclk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * QD && m_if.valid; i++) cyc(1'b0, '0, 1'b1);
      chkn("drained", longint'(m_if.valid), 0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int target, ncyc;
      areset      = 1'b1;
      s_if.valid  = 1'b0;
      s_if.data   = '0;
      m_if.ready  = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      chkn("reset_ready", longint'(s_if.ready), 1);
      areset = 1'b0;

      // Single entry 0xA5: visible one cycle after acceptance.
      cyc(1'b1, 96'hA5, 1'b0);
      chkn("single_valid", longint'(m_if.valid), 1);
      chk("single_data", m_if.data, 96'hA5);
      chkn("single_occ", longint'(occ), 1);
      cyc(1'b0, '0, 1'b1);
      chkn("single_pop_occ", longint'(occ), 0);
      chkn("single_pop_valid", longint'(m_if.valid), 0);

      // Fill with consumer stalled.
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, rnd96(), 1'b0);
         if (i == 4) chkn("afull_at5", longint'(afull), 0);
         if (i == 5) chkn("afull_at6", longint'(afull), 1);
      end
      chkn("full_occ", longint'(occ), QD);
      chkn("full_ready", longint'(s_if.ready), 0);

      // One pop from full: ready stays low this cycle, rises next cycle.
      s_if.valid = 1'b1;
      s_if.data  = rnd96();
      m_if.ready = 1'b1;
      chkn("full_pop_same_cycle_ready", longint'(s_if.ready), 0);
      @(posedge aclk);
      #1;
      m_if.ready = 1'b0;
      s_if.valid = 1'b0;
      chkn("full_pop_occ", longint'(occ), QD - 1);
      chkn("full_pop_next_ready", longint'(s_if.ready), 1);
      drain();

      // Concurrent push/pop at occupancy 3.
      for (int i = 0; i < 3; i++) cyc(1'b1, rnd96(), 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, rnd96(), 1'b1);
      chkn("steady_occ3", longint'(occ), 3);
      drain();

      // Random traffic, 50% valid and 50% ready.
      target = n_pop + 10000;
      ncyc   = 0;
      while (n_pop < target && ncyc < 40000) begin
         cyc(1'($urandom_range(0, 1)), rnd96(), 1'($urandom_range(0, 1)));
         ncyc++;
      end
      if (n_pop < target) chkn("random_budget", n_pop, target);
      s_if.valid = 1'b0;
      drain();

      // Asynchronous reset in the middle of a burst at occupancy 5.
      for (int i = 0; i < 5; i++) cyc(1'b1, rnd96(), 1'b0);
      chkn("pre_reset_occ", longint'(occ), 5);
      s_if.valid = 1'b0;
      #1;
      areset = 1'b1;
      #1;
      chkn("mid_reset_valid", longint'(m_if.valid), 0);
      chkn("mid_reset_occ", longint'(occ), 0);
      chkn("mid_reset_ready", longint'(s_if.ready), 1);
`ifdef META_QUEUE_STATS_EN
      chkn("mid_reset_stat_push", longint'(stat_push), 0);
      chkn("mid_reset_stat_stall", longint'(stat_stall), 0);
`endif
      @(posedge aclk);
      #1;
      areset = 1'b0;
      cyc(1'b1, 96'h11, 1'b1);
      s_if.valid = 1'b0;
      chk("post_reset_data", m_if.data, 96'h11);
      chkn("post_reset_occ", longint'(occ), 1);
      drain();

      repeat (2) cyc(1'b0, '0, 1'b0);
      chkn("final_model_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/meta_queue.md
# meta_queue

Elastic buffer placed directly downstream of the 2:1 round-robin meta arbiter. Absorbs the arbiter's granted requests in a QDEPTH-deep FIFO so that backpressure from the consumer does not stall arbitration. Exposes occupancy and an almost-full flag for upstream throttling. All storage and status are registered, so arbiter combinational paths never reach the consumer's ready.

## Interface
- QDEPTH, 8: number of entries; power of two, ≥2.
- DATA_BITS, 96: width of the meta payload; must equal the metaIntf data width.
- AFULL_THR, QDEPTH-2: `afull` asserts when occupancy ≥ AFULL_THR; must be 1..QDEPTH.
- Clock/reset: one clock; reset is asynchronous and active-high.
- aclk  in  1  clock, all logic rising-edge.
- areset  in  1  asynchronous active-high reset.
- s_meta  metaIntf.s  DATA_BITS  input stream (valid/ready/data) from the arbiter's m_meta.
- m_meta  metaIntf.m  DATA_BITS  output stream to the consumer.
- occ  out  $clog2(QDEPTH)+1  current number of stored entries.
- afull  out  1  occupancy ≥ AFULL_THR.
- stat_push, stat_pop, stat_stall  out  32 each  counters; present only with META_QUEUE_STATS_EN.

## Operation
- Storage: QDEPTH × DATA_BITS array. Write pointer `wr_ptr` and read pointer `rd_ptr` are $clog2(QDEPTH) bits and wrap modulo QDEPTH. `occ` is a separate up/down counter.
- Push: `s_meta.valid & s_meta.ready`. Writes data at `wr_ptr`, then `wr_ptr++`.
- Pop: `m_meta.valid & m_meta.ready`. Advances `rd_ptr++`.
- `s_meta.ready = (occ != QDEPTH)`. Driven from registered state only; never depends on `m_meta.ready`.
- `m_meta.valid = (occ != 0)`. `m_meta.data = mem[rd_ptr]`, first-word fall-through.
- `m_meta.data` must be held stable while valid and not ready (AXI-style rule).
- Counter update:
  - push only: occ+1.
  - pop only: occ−1.
  - both or neither: unchanged.
- Full (occ==QDEPTH): ready=0. A pop in that cycle frees a slot, but ready rises only in the next cycle; there is no same-cycle pass-through.
- Empty (occ==0): valid=0. There is no bypass; a pushed entry appears one cycle later.
- Pointer wrap: pointers roll over QDEPTH−1→0 with no gap. Ordering is strict FIFO.
- Reset mid-operation: all stored entries are discarded. Pointers and occ clear asynchronously. Data contents are don't-care.

## Timing
- Reset values:
  - occ=0, afull=0 (AFULL_THR≥1), m_meta.valid=0, s_meta.ready=1 (first clock after deassertion).
  - m_meta.data=0 during reset.
  - stat_*=0.
- Latency: push accepted at edge N → m_meta.valid high after edge N, i.e. one cycle.
- Throughput: one push and one pop per cycle, sustained, when 0<occ<QDEPTH.
- `occ` and `afull` are registered and reflect the state after the previous edge.
- Reset deassertion is synchronised externally; the block only requires that areset is asynchronous-assert.

## Configuration
- META_QUEUE_STATS_EN defined:
  - stat_push increments on each push.
  - stat_pop increments on each pop.
  - stat_stall increments each cycle with `s_meta.valid & ~s_meta.ready`.
  - All three wrap at 2^32 and clear on reset.
- META_QUEUE_STATS_EN undefined: stat ports and counters are absent. Behaviour is otherwise identical.

## Structure
- lynxTypes package holds:
  - `META_QUEUE_DEPTH_DEF` (8).
  - `META_STAT_BITS` (32).
- Storage array, pointers, and occ live in this module.
- One sub-module, `meta_queue_stats`: the three counters. Instantiated only under META_QUEUE_STATS_EN.

## Test plan
- Reset then single push of 0xA5: m_meta.valid=1 one cycle later with data 0xA5; occ=1; pop → occ=0, valid=0.
- Hold m_meta.ready=0, push continuously with QDEPTH=8:
  - 8 accepted, then s_meta.ready=0 and occ=8.
  - afull rises when occ reaches 6.
  - With stats, stat_stall counts the remaining valid cycles.
- Full queue, assert m_meta.ready for 1 cycle: occ 8→7. s_meta.ready rises the following cycle, not the same cycle.
- Random valid/ready at 50% each over 10,000 transfers: output sequence equals input order; occ never exceeds 8 or goes below 0; pointers wrap many times.
- Simultaneous push and pop at occ=3 for 20 cycles: occ stays 3; data order is preserved.
- Assert areset with occ=5 mid-burst: valid=0, occ=0, ready=1 immediately; stat_* cleared; next push of 0x11 is the next output.
